// File: rtl/d_kes_pe_elu_multi_if.sv
// -----------------------------------------------------------------------------
// d_kes_pe_elu_multi_if
// Bundles the command, coefficient and status signals of the multi-lane
// error-locator-update PE. Clock and reset stay outside as plain ports.
//
// Ports (signals), lane j of a coefficient bus sits at [j*GF_ORDER +: GF_ORDER]:
//   i_INIT_PE_ELU     load v = 1, k = 1
//   i_EXECUTE_PE_ELU  start one update
//   i_v_2i_Xm1        v(X)*X^-1 coefficients
//   i_k_2i_Xm1        k(X)*X^-1 coefficients
//   i_k_2i_Xm2        k(X)*X^-2 coefficients
//   i_d_2i            discrepancy, shared by all lanes
//   i_delta_2im2      previous discrepancy, shared by all lanes
//   i_condition_2i    k-update select
//   o_v_2i_X          registered v coefficients
//   o_k_2i_X          registered k coefficients
//   o_v_deg_chk_bits  per-lane nonzero flags of o_v_2i_X
//   o_v_nonzero       any v lane nonzero
//   o_v_top_lane      highest nonzero v lane (0 if none)
//   o_busy            update in flight (pipelined build only)
//   o_done            one-cycle pulse after outputs update
// Modports: master drives commands/coefficients, slave is the PE.
// -----------------------------------------------------------------------------
interface d_kes_pe_elu_multi_if #(
   parameter int GF_ORDER  = 12,
   parameter int NUM_LANES = 4,
   parameter int DEG_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
);
   logic                            i_INIT_PE_ELU;
   logic                            i_EXECUTE_PE_ELU;
   logic [NUM_LANES*GF_ORDER-1:0]   i_v_2i_Xm1;
   logic [NUM_LANES*GF_ORDER-1:0]   i_k_2i_Xm1;
   logic [NUM_LANES*GF_ORDER-1:0]   i_k_2i_Xm2;
   logic [GF_ORDER-1:0]             i_d_2i;
   logic [GF_ORDER-1:0]             i_delta_2im2;
   logic                            i_condition_2i;
   logic [NUM_LANES*GF_ORDER-1:0]   o_v_2i_X;
   logic [NUM_LANES*GF_ORDER-1:0]   o_k_2i_X;
   logic [NUM_LANES-1:0]            o_v_deg_chk_bits;
   logic                            o_v_nonzero;
   logic [DEG_W-1:0]                o_v_top_lane;
   logic                            o_busy;
   logic                            o_done;

   modport master (
      output i_INIT_PE_ELU, i_EXECUTE_PE_ELU, i_v_2i_Xm1, i_k_2i_Xm1, i_k_2i_Xm2,
             i_d_2i, i_delta_2im2, i_condition_2i,
      input  o_v_2i_X, o_k_2i_X, o_v_deg_chk_bits, o_v_nonzero, o_v_top_lane,
             o_busy, o_done
   );

   modport slave (
      input  i_INIT_PE_ELU, i_EXECUTE_PE_ELU, i_v_2i_Xm1, i_k_2i_Xm1, i_k_2i_Xm2,
             i_d_2i, i_delta_2im2, i_condition_2i,
      output o_v_2i_X, o_k_2i_X, o_v_deg_chk_bits, o_v_nonzero, o_v_top_lane,
             o_busy, o_done
   );
endinterface

// File: rtl/d_kes_pe_elu_multi.sv
// -----------------------------------------------------------------------------
// d_kes_pe_elu_multi
// Multi-lane error-locator-update PE for the inversion-less Berlekamp-Massey
// KES datapath. Each execute updates NUM_LANES consecutive coefficients:
//   v_new[j] = delta_2im2*v[j] + d_2i*k_Xm1[j]      (GF(2^m))
//   k_new[j] = condition ? v_Xm1[j] : k_Xm2[j]
// PIPE_STAGE=1 registers the products first and commits one edge later.
//
// Ports:
//   i_clk        clock
//   i_RESET_KES  synchronous active-high reset
//   i_stop_dec   synchronous abort, same effect as reset
//   pe           d_kes_pe_elu_multi_if.slave (commands, coefficients, status)
//
// FSM states:
//   state  | meaning
//   S_IDLE | accepts init / execute
//   S_MULT | products registered, commit on next edge (PIPE_STAGE=1 only)
//   S_OUT  | outputs just updated, o_done high, commands ignored
// -----------------------------------------------------------------------------
module d_kes_pe_elu_multi #(
   parameter int                GF_ORDER   = 12,
   parameter logic [GF_ORDER:0] GF_POLY    = 13'h1053,
   parameter int                NUM_LANES  = 4,
   parameter int                PIPE_STAGE = 0,
   parameter int                DEG_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_RESET_KES,
   input  logic                  i_stop_dec,
   d_kes_pe_elu_multi_if.slave   pe
);
   typedef logic [GF_ORDER-1:0] coef_t;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MULT = 2'd1, S_OUT = 2'd2} state_t;

   // shift-and-add multiply, reducing by the field polynomial every step
   function automatic coef_t gf_mul(input coef_t a, input coef_t b);
      coef_t acc;
      coef_t sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < GF_ORDER; i++) begin
         if (b[i]) acc = acc ^ sh;
         if (sh[GF_ORDER-1]) sh = {sh[GF_ORDER-2:0], 1'b0} ^ GF_POLY[GF_ORDER-1:0];
         else                sh = {sh[GF_ORDER-2:0], 1'b0};
      end
      return acc;
   endfunction

   state_t state_q, state_d;
   logic   clr;
   logic   load_init, load_mult, load_exec;

   coef_t [NUM_LANES-1:0] v_q, k_q, v_d, k_d;
   coef_t [NUM_LANES-1:0] prod_a, prod_b, k_new;
   coef_t [NUM_LANES-1:0] prod_a_q, prod_b_q, k_mult_q;
   logic  [NUM_LANES-1:0] chk_q, chk_d;
   logic  [DEG_W-1:0]     top_q, top_d;

   assign clr = i_RESET_KES | i_stop_dec;

   always_comb begin
      prod_a = '0;
      prod_b = '0;
      k_new  = '0;
      for (int j = 0; j < NUM_LANES; j++) begin
         prod_a[j] = gf_mul(pe.i_delta_2im2, v_q[j]);
         prod_b[j] = gf_mul(pe.i_d_2i, pe.i_k_2i_Xm1[j*GF_ORDER +: GF_ORDER]);
         k_new[j]  = pe.i_condition_2i ? pe.i_v_2i_Xm1[j*GF_ORDER +: GF_ORDER]
                                       : pe.i_k_2i_Xm2[j*GF_ORDER +: GF_ORDER];
      end
   end

   always_comb begin
      state_d   = state_q;
      load_init = 1'b0;
      load_mult = 1'b0;
      load_exec = 1'b0;
      case (state_q)
         S_IDLE: begin
            // init has priority; a simultaneous execute is dropped
            if (pe.i_INIT_PE_ELU) begin
               load_init = 1'b1;
            end else if (pe.i_EXECUTE_PE_ELU) begin
               if (PIPE_STAGE != 0) begin
                  load_mult = 1'b1;
                  state_d   = S_MULT;
               end else begin
                  load_exec = 1'b1;
                  state_d   = S_OUT;
               end
            end
         end
         S_MULT: begin
            load_exec = 1'b1;
            state_d   = S_OUT;
         end
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      v_d = v_q;
      k_d = k_q;
      if (load_init) begin
         v_d    = '0;
         k_d    = '0;
         v_d[0] = coef_t'(1);
         k_d[0] = coef_t'(1);
      end else if (load_exec) begin
         for (int j = 0; j < NUM_LANES; j++) begin
            if (state_q == S_MULT) begin
               v_d[j] = prod_a_q[j] ^ prod_b_q[j];
               k_d[j] = k_mult_q[j];
            end else begin
               v_d[j] = prod_a[j] ^ prod_b[j];
               k_d[j] = k_new[j];
            end
         end
      end
   end

   // status is derived from the next v value so it registers alongside o_v
   always_comb begin
      chk_d = '0;
      top_d = '0;
      for (int j = 0; j < NUM_LANES; j++) begin
         chk_d[j] = |v_d[j];
         if (chk_d[j]) top_d = DEG_W'(j);
      end
   end

   always_ff @(posedge i_clk) begin
      if (clr) begin
         state_q  <= S_IDLE;
         v_q      <= '0;
         k_q      <= '0;
         chk_q    <= '0;
         top_q    <= '0;
         prod_a_q <= '0;
         prod_b_q <= '0;
         k_mult_q <= '0;
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         k_q     <= k_d;
         chk_q   <= chk_d;
         top_q   <= top_d;
         if (load_mult) begin
            prod_a_q <= prod_a;
            prod_b_q <= prod_b;
            k_mult_q <= k_new;
         end
      end
   end

   assign pe.o_v_2i_X         = v_q;
   assign pe.o_k_2i_X         = k_q;
   assign pe.o_v_deg_chk_bits = chk_q;
   assign pe.o_v_nonzero      = |chk_q;
   assign pe.o_v_top_lane     = top_q;
   assign pe.o_busy           = (state_q == S_MULT);
   assign pe.o_done           = (state_q == S_OUT);
endmodule

// File: tb/tb_d_kes_pe_elu_multi.sv
// -----------------------------------------------------------------------------
// tb_d_kes_pe_elu_multi
// Drives one unpipelined and one pipelined PE from the same stimulus and
// compares both against an edge-indexed behavioural model every cycle.
// -----------------------------------------------------------------------------
module tb_d_kes_pe_elu_multi;
   localparam int M  = 12;
   localparam int NL = 4;
   localparam int W  = M * NL;
   localparam int DW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, stop, init, exec, cond;
   logic [W-1:0] v_xm1, k_xm1, k_xm2;
   logic [M-1:0] d_2i, delta;

   d_kes_pe_elu_multi_if #(.GF_ORDER(M), .NUM_LANES(NL), .DEG_W(DW)) bus0 ();
   d_kes_pe_elu_multi_if #(.GF_ORDER(M), .NUM_LANES(NL), .DEG_W(DW)) bus1 ();

   assign bus0.i_INIT_PE_ELU    = init;
   assign bus0.i_EXECUTE_PE_ELU = exec;
   assign bus0.i_v_2i_Xm1       = v_xm1;
   assign bus0.i_k_2i_Xm1       = k_xm1;
   assign bus0.i_k_2i_Xm2       = k_xm2;
   assign bus0.i_d_2i           = d_2i;
   assign bus0.i_delta_2im2     = delta;
   assign bus0.i_condition_2i   = cond;
   assign bus1.i_INIT_PE_ELU    = init;
   assign bus1.i_EXECUTE_PE_ELU = exec;
   assign bus1.i_v_2i_Xm1       = v_xm1;
   assign bus1.i_k_2i_Xm1       = k_xm1;
   assign bus1.i_k_2i_Xm2       = k_xm2;
   assign bus1.i_d_2i           = d_2i;
   assign bus1.i_delta_2im2     = delta;
   assign bus1.i_condition_2i   = cond;

   d_kes_pe_elu_multi #(.GF_ORDER(M), .GF_POLY(13'h1053), .NUM_LANES(NL),
                        .PIPE_STAGE(0), .DEG_W(DW))
      dut0 (.i_clk(clk), .i_RESET_KES(rst), .i_stop_dec(stop), .pe(bus0));

   d_kes_pe_elu_multi #(.GF_ORDER(M), .GF_POLY(13'h1053), .NUM_LANES(NL),
                        .PIPE_STAGE(1), .DEG_W(DW))
      dut1 (.i_clk(clk), .i_RESET_KES(rst), .i_stop_dec(stop), .pe(bus1));

   logic [W-1:0]    dv [2];
   logic [W-1:0]    dk [2];
   logic [NL-1:0]   dchk [2];
   logic            dnz [2];
   logic [DW-1:0]   dtop [2];
   logic            dbusy [2];
   logic            ddone [2];

   assign dv[0]    = bus0.o_v_2i_X;
   assign dk[0]    = bus0.o_k_2i_X;
   assign dchk[0]  = bus0.o_v_deg_chk_bits;
   assign dnz[0]   = bus0.o_v_nonzero;
   assign dtop[0]  = bus0.o_v_top_lane;
   assign dbusy[0] = bus0.o_busy;
   assign ddone[0] = bus0.o_done;
   assign dv[1]    = bus1.o_v_2i_X;
   assign dk[1]    = bus1.o_k_2i_X;
   assign dchk[1]  = bus1.o_v_deg_chk_bits;
   assign dnz[1]   = bus1.o_v_nonzero;
   assign dtop[1]  = bus1.o_v_top_lane;
   assign dbusy[1] = bus1.o_busy;
   assign ddone[1] = bus1.o_done;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Polynomial product then long-division reduction.
   function automatic logic [M-1:0] m_gfmul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [2*M-2:0] p;
      logic [2*M-2:0] poly;
      p    = '0;
      poly = (2*M-1)'(13'h1053);
      for (int i = 0; i < M; i++)
         if (b[i]) p = p ^ ((2*M-1)'(a) << i);
      for (int i = 2*M-2; i >= M; i--)
         if (p[i]) p = p ^ (poly << (i - M));
      return p[M-1:0];
   endfunction

   // Model per instance p (latency p+1): an accepted execute at edge n
   // commits at edge n+p and the next command is accepted from edge n+p+2.
   logic [M-1:0] mv [2][NL];
   logic [M-1:0] mk [2][NL];
   logic [M-1:0] pv [2][NL];
   logic [M-1:0] pk [2][NL];
   bit           pend [2];
   longint       commit_at [2];
   longint       next_ok [2] = '{0, 0};
   longint       n_edge = 0;
   bit           done_e [2];
   bit           busy_e [2];

   always @(posedge clk) begin
      n_edge++;
      for (int p = 0; p < 2; p++) begin
         if (rst || stop) begin
            for (int j = 0; j < NL; j++) begin
               mv[p][j] = '0;
               mk[p][j] = '0;
            end
            pend[p]    = 1'b0;
            next_ok[p] = n_edge + 1;
            done_e[p]  = 1'b0;
            busy_e[p]  = 1'b0;
         end else begin
            done_e[p] = 1'b0;
            if (n_edge >= next_ok[p]) begin
               if (init) begin
                  for (int j = 0; j < NL; j++) begin
                     mv[p][j] = (j == 0) ? 12'h001 : 12'h000;
                     mk[p][j] = (j == 0) ? 12'h001 : 12'h000;
                  end
               end else if (exec) begin
                  for (int j = 0; j < NL; j++) begin
                     pv[p][j] = m_gfmul(delta, mv[p][j]) ^ m_gfmul(d_2i, k_xm1[j*M +: M]);
                     pk[p][j] = cond ? v_xm1[j*M +: M] : k_xm2[j*M +: M];
                  end
                  pend[p]      = 1'b1;
                  commit_at[p] = n_edge + p;
                  next_ok[p]   = n_edge + p + 2;
               end
            end
            if (pend[p] && commit_at[p] == n_edge) begin
               for (int j = 0; j < NL; j++) begin
                  mv[p][j] = pv[p][j];
                  mk[p][j] = pk[p][j];
               end
               pend[p]   = 1'b0;
               done_e[p] = 1'b1;
            end
            busy_e[p] = pend[p];
         end
      end
   end

   function automatic logic [W-1:0] flat_v(input int p);
      logic [W-1:0] r;
      for (int j = 0; j < NL; j++) r[j*M +: M] = mv[p][j];
      return r;
   endfunction

   function automatic logic [W-1:0] flat_k(input int p);
      logic [W-1:0] r;
      for (int j = 0; j < NL; j++) r[j*M +: M] = mk[p][j];
      return r;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         for (int p = 0; p < 2; p++) begin
            logic [NL-1:0] e_chk;
            logic [DW-1:0] e_top;
            e_chk = '0;
            e_top = '0;
            for (int j = 0; j < NL; j++) begin
               e_chk[j] = (mv[p][j] != 0);
               if (e_chk[j]) e_top = DW'(j);
            end
            check($sformatf("p%0d_v", p),    64'(dv[p]),    64'(flat_v(p)));
            check($sformatf("p%0d_k", p),    64'(dk[p]),    64'(flat_k(p)));
            check($sformatf("p%0d_chk", p),  64'(dchk[p]),  64'(e_chk));
            check($sformatf("p%0d_nz", p),   64'(dnz[p]),   64'(|e_chk));
            check($sformatf("p%0d_top", p),  64'(dtop[p]),  64'(e_top));
            check($sformatf("p%0d_busy", p), 64'(dbusy[p]), 64'(busy_e[p]));
            check($sformatf("p%0d_done", p), 64'(ddone[p]), 64'(done_e[p]));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   function automatic logic [W-1:0] rlanes();
      logic [W-1:0] r;
      r = '0;
      for (int j = 0; j < NL; j++)
         if ($urandom_range(0, 2) != 0) r[j*M +: M] = M'($urandom);
      return r;
   endfunction

   task automatic rand_data();
      v_xm1 = rlanes();
      k_xm1 = rlanes();
      k_xm2 = rlanes();
      d_2i  = M'($urandom);
      delta = M'($urandom);
      cond  = 1'($urandom);
   endtask

   int c0, c1;

   initial begin
      rst = 1'b1; stop = 1'b0; init = 1'b0; exec = 1'b0; cond = 1'b0;
      v_xm1 = '0; k_xm1 = '0; k_xm2 = '0; d_2i = '0; delta = '0;
      step(2);
      chk_en = 1'b1;
      rst = 1'b0;
      step(3);
      check("rst_v0",    64'(dv[0]),   64'h0);
      check("rst_v1",    64'(dv[1]),   64'h0);
      check("rst_top0",  64'(dtop[0]), 64'h0);
      check("rst_done1", 64'(ddone[1]), 64'h0);

      // init
      init = 1'b1;
      step(1);
      init = 1'b0;
      check("init_v0",   64'(dv[0]),   64'h1);
      check("init_k0",   64'(dk[0]),   64'h1);
      check("init_v1",   64'(dv[1]),   64'h1);
      check("init_nz0",  64'(dnz[0]),  64'h1);
      check("init_top0", 64'(dtop[0]), 64'h0);
      check("init_done0", 64'(ddone[0]), 64'h0);
      check("model_init", 64'(flat_v(0)), 64'h1);
      step(1);

      // v0 = 1*1 + 2*0x800 = 0x001 ^ 0x053
      delta = 12'h001; d_2i = 12'h002; k_xm1 = 48'h000000000800;
      cond = 1'b0; k_xm2 = 48'h000ABC000000; v_xm1 = rlanes();
      exec = 1'b1;
      step(1);
      exec = 1'b0;
      rand_data();
      check("ex1_v0",     64'(dv[0]),    64'h52);
      check("ex1_k0",     64'(dk[0]),    64'h000ABC000000);
      check("ex1_done0",  64'(ddone[0]), 64'h1);
      check("ex1_busy1",  64'(dbusy[1]), 64'h1);
      check("ex1_hold1",  64'(dv[1]),    64'h1);
      check("model_ex1",  64'(flat_v(0)), 64'h52);
      step(1);
      check("ex1_done0b", 64'(ddone[0]), 64'h0);
      check("ex1_done1",  64'(ddone[1]), 64'h1);
      check("ex1_v1",     64'(dv[1]),    64'h52);
      check("ex1_k1",     64'(dk[1]),    64'h000ABC000000);
      step(1);

      delta = 12'h001; d_2i = 12'h001; k_xm1 = 48'h123000000000;
      cond = 1'b1; v_xm1 = 48'h000000055000; k_xm2 = rlanes();
      exec = 1'b1;
      step(1);
      exec = 1'b0;
      step(1);
      check("ex2_v0",   64'(dv[0]),   64'h123000000052);
      check("ex2_top0", 64'(dtop[0]), 64'h3);
      check("ex2_k0",   64'(dk[0]),   64'h000000055000);
      check("ex2_v1",   64'(dv[1]),   64'h123000000052);
      check("ex2_top1", 64'(dtop[1]), 64'h3);
      check("ex2_k1",   64'(dk[1]),   64'h000000055000);
      step(3);

      // execute held for 4 cycles
      c0 = 0; c1 = 0;
      exec = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_data();
         step(1);
         if (ddone[0]) c0++;
         if (ddone[1]) c1++;
      end
      exec = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         if (ddone[0]) c0++;
         if (ddone[1]) c1++;
      end
      check("held_dones0", 64'(c0), 64'd2);
      check("held_dones1", 64'(c1), 64'd2);

      // abort while the pipelined instance is in its multiply cycle
      rand_data();
      exec = 1'b1;
      step(1);
      exec = 1'b0;
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      check("abort_v1",    64'(dv[1]),    64'h0);
      check("abort_k1",    64'(dk[1]),    64'h0);
      check("abort_done1", 64'(ddone[1]), 64'h0);
      check("abort_busy1", 64'(dbusy[1]), 64'h0);
      check("abort_v0",    64'(dv[0]),    64'h0);
      step(1);
      check("abort_done1b", 64'(ddone[1]), 64'h0);
      delta = M'($urandom); d_2i = 12'h001; k_xm1 = 48'h0000000AB000;
      exec = 1'b1;
      step(1);
      exec = 1'b0;
      step(1);
      check("post_abort_v1",    64'(dv[1]),    64'h0000000AB000);
      check("post_abort_done1", 64'(ddone[1]), 64'h1);
      check("post_abort_top1",  64'(dtop[1]),  64'h1);
      step(2);

      // init and execute together: init wins
      rand_data();
      init = 1'b1;
      exec = 1'b1;
      step(1);
      init = 1'b0;
      exec = 1'b0;
      check("initex_v0",    64'(dv[0]),    64'h1);
      check("initex_done0", 64'(ddone[0]), 64'h0);
      check("initex_busy1", 64'(dbusy[1]), 64'h0);
      step(1);
      check("initex_done1", 64'(ddone[1]), 64'h0);
      check("initex_v1",    64'(dv[1]),    64'h1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 199) == 0);
         stop = ($urandom_range(0, 99) == 0);
         init = ($urandom_range(0, 19) == 0);
         exec = ($urandom_range(0, 9) < 4);
         rand_data();
         step(1);
      end
      rst = 1'b0; stop = 1'b0; init = 1'b0; exec = 1'b0;
      step(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/d_kes_pe_elu_multi.md
Name: d_kes_pe_elu_multi

Overview:
- Parametrised multi-lane error-locator-update processing element for the BCH KES (inversion-less Berlekamp-Massey) datapath. Normal order.
- Updates NUM_LANES consecutive coefficients of v(X) and k(X) per execute command, using one shared delta/discrepancy pair.
- Adds an optional multiplier pipeline stage, a polynomial-init command, a done strobe, a busy flag and degree reporting.
- Replaces banks of single-coefficient PEs in the KES array.

Parameters:
- GF_ORDER, 12, field width m; every coefficient is m bits.
- GF_POLY, 13'h1053, primitive polynomial including the x^m term (default x^12+x^6+x^4+x+1).
- NUM_LANES, 4, coefficients handled per instance; must be 1 or more.
- PIPE_STAGE, 0, 0 = outputs on the execute edge; 1 = product register stage, outputs one edge later.
- DEG_W, $clog2(NUM_LANES) with minimum 1, width of the degree index.

Ports:
- i_clk, in, 1, clock.
- i_RESET_KES, in, 1, synchronous active-high reset.
- i_stop_dec, in, 1, synchronous abort; identical effect to reset.
- i_INIT_PE_ELU, in, 1, load v=1, k=1 (lane 0 = 1, other lanes 0).
- i_EXECUTE_PE_ELU, in, 1, start one update.
- i_v_2i_Xm1, in, NUM_LANES*GF_ORDER, v(X)·X^-1 coefficients; lane j at [j*m +: m].
- i_k_2i_Xm1, in, NUM_LANES*GF_ORDER, k(X)·X^-1 coefficients.
- i_k_2i_Xm2, in, NUM_LANES*GF_ORDER, k(X)·X^-2 coefficients.
- i_d_2i, in, GF_ORDER, discrepancy d_2i (shared by all lanes).
- i_delta_2im2, in, GF_ORDER, previous discrepancy (shared by all lanes).
- i_condition_2i, in, 1, k-update select.
- o_v_2i_X, out, NUM_LANES*GF_ORDER, registered v coefficients.
- o_k_2i_X, out, NUM_LANES*GF_ORDER, registered k coefficients.
- o_v_deg_chk_bits, out, NUM_LANES, per-lane OR-reduce of o_v_2i_X (bit j for lane j).
- o_v_nonzero, out, 1, OR of o_v_deg_chk_bits.
- o_v_top_lane, out, DEG_W, highest lane index with a nonzero v coefficient; 0 if none.
- o_busy, out, 1, high while an update is in flight (PIPE_STAGE=1 only).
- o_done, out, 1, one-cycle pulse after the outputs update.

Behaviour:
- Reset: if i_RESET_KES or i_stop_dec is high at a clock edge, all outputs and internal registers go to 0 and the FSM goes to IDLE. Reset has priority over every other input.
- FSM states:
  - IDLE to OUT on execute when PIPE_STAGE=0.
  - IDLE to MULT on execute when PIPE_STAGE=1.
  - MULT to OUT unconditionally.
  - OUT to IDLE unconditionally.
- Per-lane update, for j = 0..NUM_LANES-1 (GF mult is full parallel multiply reduced by GF_POLY; + is XOR):
  - v_new[j] = delta_2im2 ⊗ o_v_2i_X[j] ⊕ d_2i ⊗ i_k_2i_Xm1[j].
  - k_new[j] = i_condition_2i ? i_v_2i_Xm1[j] : i_k_2i_Xm2[j].
- PIPE_STAGE=0:
  - On the edge where execute is sampled in IDLE, o_v/o_k load v_new/k_new; FSM enters OUT.
  - o_done is high during the OUT cycle. Latency is 1 edge.
  - All inputs need to be valid only at the sampling edge.
- PIPE_STAGE=1:
  - At the sampling edge, both products per lane and k_new are registered; o_busy goes high.
  - At the next edge, outputs load the XOR of the registered products; FSM enters OUT, o_busy goes low, o_done is high for that cycle.
  - Inputs may change after the sampling edge.
- Execute handling:
  - Execute while not in IDLE is ignored; it is neither queued nor counted.
  - Execute in the OUT cycle is ignored, so back-to-back updates require 2 cycles (PIPE=0) or 3 cycles (PIPE=1) apart.
- Init:
  - i_INIT_PE_ELU in IDLE sets lane 0 of o_v and o_k to 1 and all other lanes to 0 at that edge. No done pulse.
  - Init and execute in the same cycle: init wins and execute is dropped.
  - Init outside IDLE is ignored.
- Outputs hold their value whenever no update or init occurs.
- Status outputs are registered together with o_v, so they are coherent with o_v in the same cycle:
  - o_v_deg_chk_bits[j] = |o_v_2i_X[j].
  - o_v_top_lane = index of the highest set bit of o_v_deg_chk_bits.
- Reset or abort during MULT discards the in-flight update: no done pulse, outputs are 0.

Test Plan:
- Reset, then idle: all outputs 0, o_done never pulses, o_v_top_lane=0.
- Init with NUM_LANES=4: o_v lane0=0x001, other lanes 0; o_k the same; o_v_nonzero=1, o_v_top_lane=0, o_done=0.
- After init, execute with delta=0x001, d=0x002, k_Xm1 lane0=0x800 (others 0), condition=0, k_Xm2 lane2=0xABC:
  - v lane0 = 0x001 ⊕ 0x053 = 0x052.
  - o_k lane2 = 0xABC.
  - PIPE=0: o_done one cycle later; PIPE=1: two cycles later.
- Execute with delta=0x001, d=0x001, k_Xm1 lane3=0x123, condition=1, v_Xm1 lane1=0x055:
  - v lane3 = 0x123; o_v_top_lane=3.
  - o_k lane1 = 0x055.
- Execute held high for 4 cycles: exactly 2 updates (PIPE=0) or 1 update plus a second at cycle 3 (PIPE=1); each update gives a single done pulse.
- PIPE=1: execute, then i_stop_dec in the MULT cycle: no o_done, all outputs 0, FSM in IDLE; the next execute works normally.
